fetch_unit: RTL and testbench

- Instruction-fetch stage directly upstream of decode and the 8-bit register file.
- Holds the program counter and issues one request at a time to instruction memory over a req/ack handshake.
- Buffers the returned instruction and presents it to decode over a valid/ready handshake.
- Applies branches (absolute register target or PC-relative offset), halt and restart.

---
 rtl/fetch_unit_pkg.sv | 14 +
 rtl/fetch_unit_prog_ctr.sv | 56 +++++
 rtl/fetch_unit.sv | 103 ++++++++++
 tb/tb_fetch_unit.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared fetch-stage widths and state encoding
package fetch_unit_pkg;

  localparam int kPcWidth   = 10;
  localparam int kInstWidth = 9;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FETCH  = 2'd1,
    HOLD   = 2'd2,
    HALTED = 2'd3
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit_prog_ctr.sv
// rtl/fetch_unit_prog_ctr.sv - program counter register and next-PC select
module fetch_unit_prog_ctr
  import fetch_unit_pkg::*;
#(
  parameter int PW = kPcWidth,
  parameter int W  = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_load,
  input  logic [PW-1:0] i_start_addr,
  input  logic          i_advance,
  input  logic          i_branch_en,
  input  logic          i_branch_rel,
  input  logic [W-1:0]  i_branch_target,
  input  logic [PW-1:0] i_base,
  output logic [PW-1:0] o_pc
);

  logic [PW-1:0] r_pc;
  logic [PW-1:0] w_abs;
  logic [PW-1:0] w_rel;
  logic [PW-1:0] w_seq;
  logic [PW-1:0] w_next;

  // Relative targets are signed offsets from the accepted instruction's address.
  assign w_abs = {{(PW-W){1'b0}}, i_branch_target};
  assign w_rel = i_base + {{(PW-W){i_branch_target[W-1]}}, i_branch_target};
  assign w_seq = i_base + PW'(1);

  always_comb begin
    w_next = r_pc;
    if (i_load) begin
      w_next = i_start_addr;
    end else if (i_advance) begin
      if (i_branch_en && i_branch_rel) begin
        w_next = w_rel;
      end else if (i_branch_en) begin
        w_next = w_abs;
      end else begin
        w_next = w_seq;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc <= '0;
    end else begin
      r_pc <= w_next;
    end
  end

  assign o_pc = r_pc;

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, imem handshake, decode buffer
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int PW = kPcWidth,
  parameter int IW = kInstWidth,
  parameter int W  = 8,
  parameter int CW = 16
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  input  logic [PW-1:0] StartAddr,
  output logic          ImemReq,
  output logic [PW-1:0] ImemAddr,
  input  logic          ImemAck,
  input  logic [IW-1:0] ImemData,
  output logic          InstValid,
  input  logic          InstReady,
  output logic [IW-1:0] InstOut,
  output logic [PW-1:0] PcOut,
  input  logic          BranchEn,
  input  logic          BranchRel,
  input  logic [W-1:0]  BranchTarget,
  input  logic          HaltReq,
  output logic          Done,
  output logic [CW-1:0] InstCount
);

  fetch_state_t  r_state;
  fetch_state_t  w_next_state;
  logic [IW-1:0] r_inst;
  logic [PW-1:0] r_pc_out;
  logic [CW-1:0] r_count;
  logic [PW-1:0] w_pc;
  logic          w_accept;
  logic          w_load;
  logic          w_advance;

  assign w_accept  = (r_state == HOLD) && InstReady;
  assign w_load    = Start && ((r_state == IDLE) || (r_state == HALTED));
  assign w_advance = w_accept && !HaltReq;

  fetch_unit_prog_ctr #(
    .PW(PW),
    .W (W)
  ) u_prog_ctr (
    .clk            (Clk),
    .rst            (Reset),
    .i_load         (w_load),
    .i_start_addr   (StartAddr),
    .i_advance      (w_advance),
    .i_branch_en    (BranchEn),
    .i_branch_rel   (BranchRel),
    .i_branch_target(BranchTarget),
    .i_base         (r_pc_out),
    .o_pc           (w_pc)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE, HALTED: if (Start) w_next_state = FETCH;
      FETCH:        if (ImemAck) w_next_state = HOLD;
      HOLD:         if (w_accept) w_next_state = HaltReq ? HALTED : FETCH;
      default:      w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_inst   <= '0;
      r_pc_out <= '0;
      r_count  <= '0;
    end else begin
      if ((r_state == FETCH) && ImemAck) begin
        r_inst   <= ImemData;
        r_pc_out <= w_pc;
      end
      if (w_accept) begin
        r_count <= r_count + CW'(1);
      end
    end
  end

  // Outputs decode straight from state so an async reset drops them at once.
  assign ImemReq   = (r_state == FETCH);
  assign ImemAddr  = w_pc;
  assign InstValid = (r_state == HOLD);
  assign Done      = (r_state == HALTED);
  assign InstOut   = r_inst;
  assign PcOut     = r_pc_out;
  assign InstCount = r_count;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed table-driven bench for fetch_unit
module tb_fetch_unit;

  logic        Clk = 1'b0;
  logic        Reset = 1'b1;
  logic        Start = 1'b0;
  logic [9:0]  StartAddr = '0;
  logic        ImemReq;
  logic [9:0]  ImemAddr;
  logic        ImemAck = 1'b0;
  logic [8:0]  ImemData = '0;
  logic        InstValid;
  logic        InstReady = 1'b0;
  logic [8:0]  InstOut;
  logic [9:0]  PcOut;
  logic        BranchEn = 1'b0;
  logic        BranchRel = 1'b0;
  logic [7:0]  BranchTarget = '0;
  logic        HaltReq = 1'b0;
  logic        Done;
  logic [15:0] InstCount;

  int n_checks = 0;
  int n_pass   = 0;

  fetch_unit dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .Start       (Start),
    .StartAddr   (StartAddr),
    .ImemReq     (ImemReq),
    .ImemAddr    (ImemAddr),
    .ImemAck     (ImemAck),
    .ImemData    (ImemData),
    .InstValid   (InstValid),
    .InstReady   (InstReady),
    .InstOut     (InstOut),
    .PcOut       (PcOut),
    .BranchEn    (BranchEn),
    .BranchRel   (BranchRel),
    .BranchTarget(BranchTarget),
    .HaltReq     (HaltReq),
    .Done        (Done),
    .InstCount   (InstCount)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [9:0] start;
    logic [8:0] data;
    logic       br_en;
    logic       br_rel;
    logic [7:0] tgt;
    logic       halt;
    logic       exp_done;
    logic [9:0] exp_addr;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic clear_inputs();
    Start = 1'b0; ImemAck = 1'b0; InstReady = 1'b0;
    BranchEn = 1'b0; BranchRel = 1'b0; BranchTarget = '0; HaltReq = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    Reset = 1'b1;
    @(posedge Clk);
    #1 Reset = 1'b0;
  endtask

  task automatic do_start(input logic [9:0] addr);
    Start = 1'b1;
    StartAddr = addr;
    @(posedge Clk);
    #1 Start = 1'b0;
  endtask

  initial begin
    vecs[0] = '{10'h020, 9'h011, 1'b1, 1'b1, 8'hFC, 1'b0, 1'b0, 10'h01C};
    vecs[1] = '{10'h020, 9'h022, 1'b1, 1'b0, 8'h80, 1'b0, 1'b0, 10'h080};
    vecs[2] = '{10'h3FF, 9'h033, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 10'h000};
    vecs[3] = '{10'h3FF, 9'h044, 1'b1, 1'b1, 8'h02, 1'b0, 1'b0, 10'h001};
    vecs[4] = '{10'h040, 9'h055, 1'b1, 1'b0, 8'h12, 1'b1, 1'b1, 10'h000};
    vecs[5] = '{10'h005, 9'h066, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 10'h006};
    vecs[6] = '{10'h000, 9'h077, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 10'h3FF};
    vecs[7] = '{10'h100, 9'h188, 1'b1, 1'b1, 8'h7F, 1'b0, 1'b0, 10'h17F};
    vecs[8] = '{10'h123, 9'h199, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0, 10'h0FF};
    vecs[9] = '{10'h200, 9'h1AA, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0, 10'h201};

    // Reset state
    do_reset();
    @(negedge Clk);
    check("rst ImemReq", ImemReq, 0);
    check("rst InstValid", InstValid, 0);
    check("rst Done", Done, 0);
    check("rst InstOut", InstOut, 0);
    check("rst PcOut", PcOut, 0);
    check("rst InstCount", InstCount, 0);

    // Table: one fetch plus one accept with given branch/halt controls
    for (int i = 0; i < 10; i++) begin
      do_reset();
      do_start(vecs[i].start);
      ImemAck = 1'b1;
      ImemData = vecs[i].data;
      @(posedge Clk);
      #1 ImemAck = 1'b0;
      @(negedge Clk);
      check($sformatf("vec%0d valid", i), InstValid, 1);
      check($sformatf("vec%0d instout", i), InstOut, vecs[i].data);
      check($sformatf("vec%0d pcout", i), PcOut, vecs[i].start);
      InstReady = 1'b1;
      BranchEn = vecs[i].br_en;
      BranchRel = vecs[i].br_rel;
      BranchTarget = vecs[i].tgt;
      HaltReq = vecs[i].halt;
      @(posedge Clk);
      #1 clear_inputs();
      @(negedge Clk);
      check($sformatf("vec%0d done", i), Done, vecs[i].exp_done);
      check($sformatf("vec%0d count", i), InstCount, 1);
      if (vecs[i].exp_done) begin
        check($sformatf("vec%0d req", i), ImemReq, 0);
      end else begin
        check($sformatf("vec%0d req", i), ImemReq, 1);
        check($sformatf("vec%0d addr", i), ImemAddr, vecs[i].exp_addr);
      end
    end

    // Back-to-back zero-wait fetches from 0x005
    do_reset();
    do_start(10'h005);
    ImemAck = 1'b1;
    ImemData = 9'h0F0;
    InstReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      check($sformatf("seq%0d req", i), ImemReq, 1);
      check($sformatf("seq%0d addr", i), ImemAddr, 10'h005 + i);
      @(negedge Clk);
      check($sformatf("seq%0d valid", i), InstValid, 1);
      check($sformatf("seq%0d pcout", i), PcOut, 10'h005 + i);
    end
    @(negedge Clk);
    check("seq count", InstCount, 3);
    check("seq next addr", ImemAddr, 10'h008);
    clear_inputs();

    // Memory stall of 3 cycles at 0x010; a Start pulse mid-fetch is ignored
    do_reset();
    do_start(10'h010);
    for (int i = 0; i < 4; i++) begin
      @(negedge Clk);
      check($sformatf("stall%0d req", i), ImemReq, 1);
      check($sformatf("stall%0d addr", i), ImemAddr, 10'h010);
      check($sformatf("stall%0d valid", i), InstValid, 0);
      Start = (i == 1);
      StartAddr = 10'h300;
      if (i == 3) begin
        ImemAck = 1'b1;
        ImemData = 9'h1A5;
      end
    end
    @(posedge Clk);
    #1 clear_inputs();
    @(negedge Clk);
    check("stall instout", InstOut, 9'h1A5);
    check("stall pcout", PcOut, 10'h010);

    // Decode back-pressure for 5 cycles
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp%0d instout", i), InstOut, 9'h1A5);
      check($sformatf("bp%0d pcout", i), PcOut, 10'h010);
      check($sformatf("bp%0d req", i), ImemReq, 0);
      check($sformatf("bp%0d count", i), InstCount, 0);
      @(negedge Clk);
    end
    InstReady = 1'b1;
    @(posedge Clk);
    #1 clear_inputs();
    @(negedge Clk);
    check("bp accept count", InstCount, 1);
    check("bp next addr", ImemAddr, 10'h011);

    // Halt (priority over branch), stimulus ignored while halted, restart
    do_reset();
    do_start(10'h040);
    ImemAck = 1'b1;
    @(posedge Clk);
    #1 ImemAck = 1'b0;
    InstReady = 1'b1; HaltReq = 1'b1; BranchEn = 1'b1; BranchTarget = 8'h99;
    @(posedge Clk);
    #1 ImemAck = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      check($sformatf("halt%0d done", i), Done, 1);
      check($sformatf("halt%0d req", i), ImemReq, 0);
    end
    check("halt count", InstCount, 1);
    clear_inputs();
    do_start(10'h100);
    @(negedge Clk);
    check("restart done", Done, 0);
    check("restart req", ImemReq, 1);
    check("restart addr", ImemAddr, 10'h100);
    check("restart count kept", InstCount, 1);

    // Async reset mid-fetch, then a late ack is ignored
    Reset = 1'b1;
    #1;
    check("async rst req", ImemReq, 0);
    @(posedge Clk);
    #1 Reset = 1'b0;
    ImemAck = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge Clk);
      check($sformatf("late ack%0d req", i), ImemReq, 0);
      check($sformatf("late ack%0d valid", i), InstValid, 0);
    end
    clear_inputs();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
